// File: rtl/univ_shift_trx.sv
// univ_shift_trx: serial TX/RX pair built on two universal shift registers.
// TX serialises WIDTH-bit words at DIV clocks per bit; RX reframes them.
//
// Ports:
//   CLK, RESET_N              clock, async active-low reset
//   tx_data/tx_valid/tx_ready parallel word in, valid/ready accept
//   tx_lsb_first              bit order, latched when a word is accepted
//   ser_out/ser_frame         serial line out and its frame qualifier
//   ser_in/ser_in_frame       serial line in and its frame qualifier
//   rx_lsb_first              RX bit order
//   loopback                  1: RX listens to ser_out/ser_frame
//   rx_data/rx_valid          last complete word, one-cycle update pulse
//   rx_err                    one-cycle pulse: frame ended mid-word

package univ_shift_pkg;
  typedef enum logic [1:0] {
    SH_HOLD,
    SH_LEFT,
    SH_RIGHT,
    SH_LOAD
  } sh_mode_t;
endpackage

module univ_shreg
  import univ_shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         clr,
  input  sh_mode_t     mode,
  input  logic [W-1:0] load_val,
  input  logic         ser_in,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      unique case (mode)
        SH_HOLD:  q <= q;
        SH_LEFT:  q <= {q[W-2:0], ser_in};
        SH_RIGHT: q <= {ser_in, q[W-1:1]};
        SH_LOAD:  q <= load_val;
      endcase
    end
  end

endmodule

module univ_shift_trx
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             tx_lsb_first,
  output logic             ser_out,
  output logic             ser_frame,
  input  logic             ser_in,
  input  logic             ser_in_frame,
  input  logic             rx_lsb_first,
  input  logic             loopback,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } tx_state_t;

  // ---------------- TX ----------------
  tx_state_t        tx_state;
  logic             tx_lsb;
  logic [BW-1:0]    tx_bit;
  logic [DW-1:0]    tx_div;
  logic [WIDTH-1:0] tx_q;
  logic             tx_accept;
  logic             tx_tick;
  sh_mode_t         tx_mode;

  assign tx_accept = tx_ready & tx_valid;
  assign tx_tick   = ser_frame & (tx_div == DIV_LAST);

  always_comb begin
    tx_mode = SH_HOLD;
    if (tx_accept) begin
      tx_mode = SH_LOAD;
    end else if (tx_tick) begin
      tx_mode = tx_lsb ? SH_RIGHT : SH_LEFT;
    end
  end

  univ_shreg #(
    .W (WIDTH)
  ) u_tx_sh (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .clr      (1'b0),
    .mode     (tx_mode),
    .load_val (tx_data),
    .ser_in   (1'b0),
    .q        (tx_q)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state  <= IDLE;
      tx_ready  <= 1'b1;
      ser_frame <= 1'b0;
      tx_lsb    <= 1'b0;
      tx_bit    <= '0;
      tx_div    <= '0;
    end else begin
      unique case (tx_state)
        IDLE: begin
          if (tx_valid) begin
            tx_state  <= SHIFT;
            tx_ready  <= 1'b0;
            ser_frame <= 1'b1;
            tx_lsb    <= tx_lsb_first;
            tx_bit    <= '0;
            tx_div    <= '0;
          end
        end
        SHIFT: begin
          if (tx_div == DIV_LAST) begin
            tx_div <= '0;
            tx_bit <= tx_bit + BW'(1);
            if (tx_bit == BIT_LAST) begin
              tx_state  <= IDLE;
              tx_ready  <= 1'b1;
              ser_frame <= 1'b0;
            end
          end else begin
            tx_div <= tx_div + DW'(1);
          end
        end
      endcase
    end
  end

  // Line sits at 0 outside a frame.
  assign ser_out = ser_frame &
                   (tx_lsb ? tx_q[0] : tx_q[WIDTH-1]);

  // ---------------- RX ----------------
  logic             rx_frame;
  logic             rx_bit_in;
  logic [BW-1:0]    rx_bit;
  logic [DW-1:0]    rx_div;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] rx_next;
  logic             rx_tick;
  sh_mode_t         rx_mode;

  assign rx_frame  = loopback ? ser_frame : ser_in_frame;
  assign rx_bit_in = loopback ? ser_out : ser_in;
  assign rx_tick   = rx_frame & (rx_div == DIV_LAST);

  always_comb begin
    rx_mode = SH_HOLD;
    if (rx_tick) begin
      rx_mode = rx_lsb_first ? SH_RIGHT : SH_LEFT;
    end
  end

  // Word as it will look after this sample, so the
  // final sample lands in rx_data on the same edge.
  always_comb begin
    rx_next = {rx_q[WIDTH-2:0], rx_bit_in};
    unique case (1'b1)
      rx_lsb_first: rx_next = {rx_bit_in, rx_q[WIDTH-1:1]};
      default:      rx_next = {rx_q[WIDTH-2:0], rx_bit_in};
    endcase
  end

  univ_shreg #(
    .W (WIDTH)
  ) u_rx_sh (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .clr      (~rx_frame),
    .mode     (rx_mode),
    .load_val ('0),
    .ser_in   (rx_bit_in),
    .q        (rx_q)
  );

  // Counters idle at zero while the frame is low, so
  // every rising frame edge starts a fresh word.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_bit   <= '0;
      rx_div   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (!rx_frame) begin
        rx_err <= (rx_bit != '0);
        rx_bit <= '0;
        rx_div <= '0;
      end else if (rx_div == DIV_LAST) begin
        rx_div <= '0;
        if (rx_bit == BIT_LAST) begin
          rx_bit   <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          rx_bit <= rx_bit + BW'(1);
        end
      end else begin
        rx_div <= rx_div + DW'(1);
      end
    end
  end

endmodule
